drawing_rect_fill: RTL and testbench

Parametrised rectangle fill engine, the next generation of the team's rectangle drawer. It sits between the processor register interface (`req`/`ack`, `r0`..`r9`) and the frame-store data-engine bus (`de_*`). It draws a clipped rectangle row-major with 16-bit width and height, signed origin and four draw modes. The modes are solid, opaque pattern, transparent pattern, and invert, where invert is a read-modify-write.

---
 rtl/drawing_rect_fill.sv | 245 ++++++++++++++++++++++++
 tb/tb_drawing_rect_fill.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/drawing_rect_fill.sv
// Rectangle fill engine: clips a signed-origin rectangle to the screen and draws it
// row-major over the frame-store bus in solid, opaque/transparent pattern or invert mode.
module drawing_rect_fill #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned SCREEN_W = 640,
  parameter int unsigned SCREEN_H = 480,
  parameter int unsigned ADDR_W   = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req,
  output logic                ack,
  output logic                busy,
  input  logic [15:0]         r0,
  input  logic [15:0]         r1,
  input  logic [15:0]         r2,
  input  logic [15:0]         r3,
  input  logic [15:0]         r4,
  input  logic [15:0]         r5,
  input  logic [15:0]         r6,
  input  logic [15:0]         r7,
  input  logic [15:0]         r8,
  input  logic [15:0]         r9,
  output logic                de_req,
  input  logic                de_ack,
  output logic [ADDR_W-1:0]   de_addr,
  output logic [DATA_W/8-1:0] de_nbyte,
  output logic                de_rnw,
  output logic [DATA_W-1:0]   de_w_data,
  input  logic [DATA_W-1:0]   de_r_data
);
  localparam int unsigned PPW = DATA_W / 8;
  localparam int unsigned WPR = SCREEN_W / PPW;
  localparam int unsigned LW  = $clog2(PPW);
  localparam int unsigned XW  = $clog2(SCREEN_W);
  localparam int unsigned YW  = $clog2(SCREEN_H);
  localparam logic signed [17:0] XMAX = 18'(SCREEN_W - 1);
  localparam logic signed [17:0] YMAX = 18'(SCREEN_H - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_CLIP, S_LINE, S_READ, S_WRITE, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic              ack_q, ack_d, busy_q, busy_d;
  logic              de_req_q, de_req_d, de_rnw_q, de_rnw_d;
  logic [PPW-1:0]    de_nbyte_q, de_nbyte_d, mask_q, mask_d;
  logic [ADDR_W-1:0] de_addr_q, de_addr_d;
  logic [DATA_W-1:0] de_w_data_q, de_w_data_d;
  logic [15:0]       x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [7:0]        fg_q, fg_d, bg_q, bg_d;
  logic [1:0]        mode_q, mode_d;
  logic [63:0]       pat_q, pat_d;
  logic [XW-1:0]     x0_q, x0_d, x1_q, x1_d, cw_q, cw_d;
  logic [YW-1:0]     y1_q, y1_d, cy_q, cy_d;

  logic unused_r5;
  assign unused_r5 = ^r5[15:2];

  // Clip window in 18-bit signed arithmetic
  logic signed [17:0] xs, ys, xe, ye, cx0, cx1, cy0, cy1;
  logic               empty;
  always_comb begin
    xs    = {{2{x_q[15]}}, x_q};
    ys    = {{2{y_q[15]}}, y_q};
    xe    = xs + $signed({2'b00, w_q}) - 18'sd1;
    ye    = ys + $signed({2'b00, h_q}) - 18'sd1;
    cx0   = xs[17] ? '0 : xs;
    cy0   = ys[17] ? '0 : ys;
    cx1   = (xe > XMAX) ? XMAX : xe;
    cy1   = (ye > YMAX) ? YMAX : ye;
    empty = (w_q == '0) || (h_q == '0) || (cx0 > cx1) || (cy0 > cy1);
  end

  // LINE looks at the first word of the row; a pending write looks one word ahead
  // so consecutive non-empty words go out back-to-back.
  logic [XW-1:0] x0w, x1w, eval_w;
  assign x0w = x0_q >> LW;
  assign x1w = x1_q >> LW;
  always_comb begin
    eval_w = cw_q;
    if (state_q == S_LINE) eval_w = x0w;
    else if (de_req_q)     eval_w = cw_q + 1'b1;
  end

  logic [PPW-1:0]    ev_en;
  logic [DATA_W-1:0] ev_data;
  logic [ADDR_W-1:0] ev_addr;
  logic [7:0]        pat_row;
  logic [31:0]       px;
  logic              on;
  always_comb begin
    pat_row = pat_q[{cy_q[2:0], 3'b000} +: 8];
    ev_en   = '0;
    ev_data = '0;
    px      = '0;
    on      = 1'b0;
    for (int unsigned k = 0; k < PPW; k++) begin
      px       = 32'(eval_w) * PPW + k;
      on       = pat_row[px[2:0]];
      ev_en[k] = (px >= 32'(x0_q)) && (px <= 32'(x1_q)) && (!mode_q[1] || on);
      ev_data[8*k +: 8] = (mode_q == 2'd1 && !on) ? bg_q : fg_q;
    end
    ev_addr = ADDR_W'(32'(cy_q) * WPR + 32'(eval_w));
  end

  logic [DATA_W-1:0] inv_data;
  always_comb begin
    inv_data = de_r_data;
    for (int unsigned k = 0; k < PPW; k++)
      if (mask_q[k]) inv_data[8*k +: 8] = ~de_r_data[8*k +: 8];
  end

  logic issue, row_end;
  always_comb begin
    state_d     = state_q;
    ack_d       = ack_q;
    busy_d      = busy_q;
    de_req_d    = de_req_q;
    de_rnw_d    = de_rnw_q;
    de_nbyte_d  = de_nbyte_q;
    de_addr_d   = de_addr_q;
    de_w_data_d = de_w_data_q;
    mask_d      = mask_q;
    x_d = x_q; y_d = y_q; w_d = w_q; h_d = h_q;
    fg_d = fg_q; bg_d = bg_q; mode_d = mode_q; pat_d = pat_q;
    x0_d = x0_q; x1_d = x1_q; y1_d = y1_q; cy_d = cy_q; cw_d = cw_q;
    issue   = 1'b0;
    row_end = 1'b0;
    unique case (state_q)
      S_IDLE: if (req) begin
        x_d = r0; y_d = r1; w_d = r2; h_d = r3;
        fg_d = r4[15:8]; bg_d = r4[7:0]; mode_d = r5[1:0];
        pat_d   = {r9, r8, r7, r6};
        ack_d   = 1'b1;
        busy_d  = 1'b1;
        state_d = S_ACK;
      end
      S_ACK: begin
        ack_d   = 1'b0;
        state_d = S_CLIP;
      end
      S_CLIP: if (empty) begin
        busy_d  = 1'b0;
        state_d = S_DONE;
      end else begin
        x0_d    = cx0[XW-1:0];
        x1_d    = cx1[XW-1:0];
        y1_d    = cy1[YW-1:0];
        cy_d    = cy0[YW-1:0];
        state_d = S_LINE;
      end
      S_LINE: begin
        if (|ev_en)            issue = 1'b1;
        else if (x0w == x1w)   row_end = 1'b1;
        else begin
          cw_d    = x0w + 1'b1;
          state_d = S_WRITE;
        end
      end
      S_READ: if (de_ack) begin
        de_rnw_d    = 1'b0;
        de_nbyte_d  = ~mask_q;
        de_w_data_d = inv_data;
        state_d     = S_WRITE;
      end
      S_WRITE: if (!de_req_q || de_ack) begin
        if (de_req_q && cw_q == x1w)       row_end = 1'b1;
        else if (|ev_en)                   issue = 1'b1;
        else if (!de_req_q && cw_q == x1w) row_end = 1'b1;
        else begin
          de_req_d = 1'b0;
          cw_d     = cw_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      cw_d      = eval_w;
      mask_d    = ev_en;
      de_req_d  = 1'b1;
      de_addr_d = ev_addr;
      if (mode_q == 2'd3) begin
        de_rnw_d   = 1'b1;
        de_nbyte_d = '0;
        state_d    = S_READ;
      end else begin
        de_rnw_d    = 1'b0;
        de_nbyte_d  = ~ev_en;
        de_w_data_d = ev_data;
        state_d     = S_WRITE;
      end
    end
    if (row_end) begin
      de_req_d = 1'b0;
      if (cy_q == y1_q) begin
        busy_d  = 1'b0;
        state_d = S_DONE;
      end else begin
        cy_d    = cy_q + 1'b1;
        state_d = S_LINE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ack_q       <= 1'b0;
      busy_q      <= 1'b0;
      de_req_q    <= 1'b0;
      de_rnw_q    <= 1'b0;
      de_nbyte_q  <= '1;
      de_addr_q   <= '0;
      de_w_data_q <= '0;
      mask_q      <= '0;
      x_q <= '0; y_q <= '0; w_q <= '0; h_q <= '0;
      fg_q <= '0; bg_q <= '0; mode_q <= '0; pat_q <= '0;
      x0_q <= '0; x1_q <= '0; y1_q <= '0; cy_q <= '0; cw_q <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      de_req_q    <= de_req_d;
      de_rnw_q    <= de_rnw_d;
      de_nbyte_q  <= de_nbyte_d;
      de_addr_q   <= de_addr_d;
      de_w_data_q <= de_w_data_d;
      mask_q      <= mask_d;
      x_q <= x_d; y_q <= y_d; w_q <= w_d; h_q <= h_d;
      fg_q <= fg_d; bg_q <= bg_d; mode_q <= mode_d; pat_q <= pat_d;
      x0_q <= x0_d; x1_q <= x1_d; y1_q <= y1_d; cy_q <= cy_d; cw_q <= cw_d;
    end
  end

  assign ack       = ack_q;
  assign busy      = busy_q;
  assign de_req    = de_req_q;
  assign de_rnw    = de_rnw_q;
  assign de_nbyte  = de_nbyte_q;
  assign de_addr   = de_addr_q;
  assign de_w_data = de_w_data_q;
endmodule

// File: tb/tb_drawing_rect_fill.sv
// Directed bench for drawing_rect_fill: hand-computed bus transfers for each draw mode,
// clipping, bus wait/abort and an empty rectangle.
module tb_drawing_rect_fill;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req, ack, busy, de_req, de_ack, de_rnw;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9;
  logic [17:0] de_addr;
  logic [3:0]  de_nbyte;
  logic [31:0] de_w_data, de_r_data;

  int n_chk = 0;
  int n_bad = 0;

  typedef struct {
    logic [17:0] a;
    logic [3:0]  nb;
    logic        rnw;
    logic [31:0] d;
    int          t;
  } xfer_t;
  xfer_t xq[$];
  xfer_t e0, e1;
  int    ack_cnt, ack_t, req_t, req_cyc, busy_lo_t, cnt, bad;

  drawing_rect_fill #(.DATA_W(32), .SCREEN_W(640), .SCREEN_H(480), .ADDR_W(18)) dut (
    .clk(clk), .rst(rst), .req(req), .ack(ack), .busy(busy),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .r5(r5), .r6(r6), .r7(r7), .r8(r8), .r9(r9),
    .de_req(de_req), .de_ack(de_ack), .de_addr(de_addr), .de_nbyte(de_nbyte),
    .de_rnw(de_rnw), .de_w_data(de_w_data), .de_r_data(de_r_data)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic xfer_t xget(input int i);
    xfer_t e;
    e.a = '1; e.nb = '1; e.rnw = 1'b1; e.d = '1; e.t = -1;
    if (i < xq.size()) e = xq[i];
    return e;
  endfunction

  task automatic start(input logic [15:0] x, y, w, h, col, md, p6, input logic hold);
    @(posedge clk); #1;
    r0 = x; r1 = y; r2 = w; r3 = h; r4 = col; r5 = md;
    r6 = p6; r7 = 16'h0000; r8 = 16'h0000; r9 = 16'h0000;
    req = 1'b1;
    xq.delete();
    ack_cnt = 0; ack_t = -1; req_t = -1; req_cyc = 0; busy_lo_t = -1;
    @(posedge clk); #1;
    if (!hold) req = 1'b0;
  endtask

  // t counts negedges after the edge that sampled req
  task automatic run(input int limit);
    int t = 0;
    bit done = 1'b0;
    while (!done && t < limit) begin
      @(negedge clk);
      t++;
      if (ack) begin
        ack_cnt++;
        if (ack_t < 0) ack_t = t;
      end
      if (de_req) begin
        req_cyc++;
        if (req_t < 0) req_t = t;
      end
      if (de_req && de_ack) begin
        xfer_t e;
        e.a = de_addr; e.nb = de_nbyte; e.rnw = de_rnw; e.d = de_w_data; e.t = t;
        xq.push_back(e);
      end
      if (!busy) begin
        busy_lo_t = t;
        done = 1'b1;
      end
    end
    if (!done) chk("run_timeout", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = 1'b0; de_ack = 1'b0; de_r_data = '0;
    r0 = '0; r1 = '0; r2 = '0; r3 = '0; r4 = '0;
    r5 = '0; r6 = '0; r7 = '0; r8 = '0; r9 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_de_req", de_req, 0);
    chk("rst_de_rnw", de_rnw, 0);
    chk("rst_nbyte", de_nbyte, 4'hF);
    chk("rst_addr", de_addr, 0);
    chk("rst_wdata", de_w_data, 0);

    de_ack = 1'b1;

    // solid, mode field upper bits set and ignored
    start(16'd5, 16'd2, 16'd6, 16'd1, 16'hE000, 16'hFFFC, 16'h0000, 1'b0);
    run(100);
    e0 = xget(0); e1 = xget(1);
    chk("solid_ack_t", ack_t, 1);
    chk("solid_ack_cnt", ack_cnt, 1);
    chk("solid_req_t", req_t, 4);
    chk("solid_n", xq.size(), 2);
    chk("solid_a0", e0.a, 321);
    chk("solid_nb0", e0.nb, 4'b0001);
    chk("solid_d0", e0.d, 32'hE0E0E0E0);
    chk("solid_rnw0", e0.rnw, 0);
    chk("solid_a1", e1.a, 322);
    chk("solid_nb1", e1.nb, 4'b1000);
    chk("solid_d1", e1.d, 32'hE0E0E0E0);
    chk("solid_t1", e1.t, 5);
    chk("solid_busy_lo", busy_lo_t, 6);

    // clipped at left and bottom
    start(16'hFFFD, 16'd478, 16'd5, 16'd4, 16'hE000, 16'd0, 16'h0000, 1'b0);
    run(100);
    e0 = xget(0); e1 = xget(1);
    chk("clip_n", xq.size(), 2);
    chk("clip_a0", e0.a, 76480);
    chk("clip_nb0", e0.nb, 4'b1100);
    chk("clip_a1", e1.a, 76640);
    chk("clip_nb1", e1.nb, 4'b1100);

    // transparent pattern: second word has no on pixel
    start(16'd0, 16'd0, 16'd8, 16'd1, 16'hFF00, 16'd2, 16'h000F, 1'b0);
    run(100);
    e0 = xget(0);
    chk("trans_n", xq.size(), 1);
    chk("trans_req_cyc", req_cyc, 1);
    chk("trans_a0", e0.a, 0);
    chk("trans_nb0", e0.nb, 4'b0000);
    chk("trans_d0", e0.d, 32'hFFFFFFFF);

    // invert: read then write with no idle cycle
    de_r_data = 32'h12345678;
    start(16'd0, 16'd1, 16'd2, 16'd1, 16'h0000, 16'd3, 16'hFFFF, 1'b0);
    run(100);
    e0 = xget(0); e1 = xget(1);
    chk("inv_n", xq.size(), 2);
    chk("inv_a0", e0.a, 160);
    chk("inv_rnw0", e0.rnw, 1);
    chk("inv_nb0", e0.nb, 4'b0000);
    chk("inv_t0", e0.t, 4);
    chk("inv_a1", e1.a, 160);
    chk("inv_rnw1", e1.rnw, 0);
    chk("inv_nb1", e1.nb, 4'b1100);
    chk("inv_d1", e1.d, 32'h1234A987);
    chk("inv_t1", e1.t, 5);

    // bus wait then abort by reset
    de_ack = 1'b0;
    start(16'd8, 16'd3, 16'd4, 16'd1, 16'h3C00, 16'd0, 16'h0000, 1'b0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!de_req && cnt < 20);
    chk("wait_req_seen", de_req, 1);
    chk("wait_req_t", cnt, 4);
    chk("wait_addr", de_addr, 482);
    chk("wait_nbyte", de_nbyte, 4'b0000);
    chk("wait_data", de_w_data, 32'h3C3C3C3C);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (de_req !== 1'b1 || de_addr !== 18'd482 || de_w_data !== 32'h3C3C3C3C ||
          de_nbyte !== 4'h0 || de_rnw !== 1'b0) bad++;
    end
    chk("wait_stable", bad, 0);
    rst = 1'b1;
    de_ack = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("abort_de_req", de_req, 0);
    chk("abort_busy", busy, 0);
    chk("abort_nbyte", de_nbyte, 4'hF);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (de_req || busy) bad++;
    end
    chk("abort_quiet", bad, 0);

    // opaque pattern right after the abort
    start(16'd0, 16'd0, 16'd4, 16'd1, 16'hAA55, 16'd1, 16'h0005, 1'b0);
    run(100);
    e0 = xget(0);
    chk("opq_ack_t", ack_t, 1);
    chk("opq_n", xq.size(), 1);
    chk("opq_a0", e0.a, 0);
    chk("opq_nb0", e0.nb, 4'b0000);
    chk("opq_d0", e0.d, 32'h55AA55AA);

    // zero width with req held through busy
    start(16'd10, 16'd10, 16'd0, 16'd5, 16'hFF00, 16'd0, 16'h0000, 1'b1);
    run(50);
    req = 1'b0;
    chk("zero_ack_cnt", ack_cnt, 1);
    chk("zero_ack_t", ack_t, 1);
    chk("zero_busy_lo", busy_lo_t, 3);
    chk("zero_req_cyc", req_cyc, 0);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (ack || busy || de_req) bad++;
    end
    chk("zero_after", bad, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
